// File: rtl/mdio_master_c45_if.sv
// Host-side request/response bus of the MDIO management master.
// The controller uses the master modport; the MDIO engine uses the slave modport.
interface mdio_master_c45_if;
  logic        i_mode;
  logic [1:0]  i_operation;
  logic [4:0]  i_phy_addr;
  logic [4:0]  i_reg_addr;
  logic [15:0] i_master_write_data;
  logic        i_operation_begin;
  logic [15:0] o_master_read_data;
  logic        o_master_read_data_valid;
  logic        o_operation_finish;
  logic        o_mdio_master_busy;
  logic        o_error;

  modport master (
    output i_mode, i_operation, i_phy_addr, i_reg_addr, i_master_write_data, i_operation_begin,
    input  o_master_read_data, o_master_read_data_valid, o_operation_finish,
    input  o_mdio_master_busy, o_error
  );

  modport slave (
    input  i_mode, i_operation, i_phy_addr, i_reg_addr, i_master_write_data, i_operation_begin,
    output o_master_read_data, o_master_read_data_valid, o_operation_finish,
    output o_mdio_master_busy, o_error
  );
endinterface

// File: rtl/mdio_master_c45.sv
// MDIO management master for Clause 22 and Clause 45 frames with configurable MDC
// divider and preamble length; drives a split-pin pad (out / oe / in).
module mdio_master_c45 #(
  parameter int unsigned CLK_DIV = 20,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic                iclk_100m,
  input  logic                sys_rst,
  mdio_master_c45_if.slave    host,
  output logic                o_mdc,
  output logic                o_mdio_out,
  output logic                o_mdio_oe,
  input  logic                i_mdio_in
);

  localparam int unsigned   CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_RISE = CW'(CLK_DIV / 2 - 1);
  localparam logic [5:0]    PRE_LAST = 6'(PRE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ST_OP, S_ADDR, S_TA, S_DATA, S_END, S_ILLEGAL
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [5:0]     bit_q, bit_d;
  logic           is_read_q, is_read_d;
  logic [31:0]    tx_q, tx_d;
  logic [15:0]    shreg_q, shreg_d;
  logic [15:0]    rdata_q, rdata_d;
  logic           noack_q, noack_d;
  logic           finish_q, finish_d;
  logic           valid_q, valid_d;
  logic           error_q, error_d;
  logic           mdc_q, mdc_d;
  logic           out_q, out_d;
  logic           oe_q, oe_d;
  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           load;

  function automatic logic [5:0] last_bit(input state_e s);
    case (s)
      S_PRE:   last_bit = PRE_LAST;
      S_ST_OP: last_bit = 6'd3;
      S_ADDR:  last_bit = 6'd9;
      S_TA:    last_bit = 6'd1;
      S_DATA:  last_bit = 6'd15;
      default: last_bit = 6'd0;
    endcase
  endfunction

  function automatic state_e next_state(input state_e s);
    case (s)
      S_PRE:   next_state = S_ST_OP;
      S_ST_OP: next_state = S_ADDR;
      S_ADDR:  next_state = S_TA;
      S_TA:    next_state = S_DATA;
      S_DATA:  next_state = S_END;
      default: next_state = S_IDLE;
    endcase
  endfunction

  always_ff @(posedge iclk_100m) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      is_read_q <= 1'b0;
      tx_q      <= '0;
      shreg_q   <= '0;
      rdata_q   <= '0;
      noack_q   <= 1'b0;
      finish_q  <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      mdc_q     <= 1'b0;
      out_q     <= 1'b1;
      oe_q      <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      is_read_q <= is_read_d;
      tx_q      <= tx_d;
      shreg_q   <= shreg_d;
      rdata_q   <= rdata_d;
      noack_q   <= noack_d;
      finish_q  <= finish_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      mdc_q     <= mdc_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    is_read_d = is_read_q;
    tx_d      = tx_q;
    shreg_d   = shreg_q;
    rdata_d   = rdata_q;
    noack_d   = noack_q;
    finish_d  = 1'b0;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    mdc_d     = mdc_q;
    out_d     = out_q;
    oe_d      = oe_q;
    sync1_d   = i_mdio_in;
    sync2_d   = sync1_q;
    load      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (host.i_operation_begin) begin
          if (!host.i_mode && (host.i_operation == 2'b00 || host.i_operation == 2'b11)) begin
            state_d  = S_ILLEGAL;
            finish_d = 1'b1;
            error_d  = 1'b1;
          end else begin
            state_d   = (PRE_LEN != 0) ? S_PRE : S_ST_OP;
            is_read_d = host.i_operation[1];
            // ST, OP, PHYAD, REGAD, TA (write form), DATA; shifted out MSB first
            tx_d      = {1'b0, ~host.i_mode, host.i_operation, host.i_phy_addr,
                         host.i_reg_addr, 2'b10, host.i_master_write_data};
            cnt_d     = '0;
            bit_d     = '0;
            noack_d   = 1'b0;
            mdc_d     = 1'b0;
            load      = 1'b1;
          end
        end
      end
      S_ILLEGAL: state_d = S_IDLE;
      default: begin
        if (cnt_q == CNT_RISE) mdc_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          mdc_d = 1'b0;
          if (is_read_q && state_q == S_TA && bit_q == 6'd1) noack_d = sync2_q;
          if (is_read_q && state_q == S_DATA) shreg_d = {shreg_q[14:0], sync2_q};
          if (state_q inside {S_ST_OP, S_ADDR, S_TA, S_DATA}) tx_d = {tx_q[30:0], 1'b0};
          if (bit_q == last_bit(state_q)) begin
            bit_d   = '0;
            state_d = next_state(state_q);
          end else begin
            bit_d = bit_q + 6'd1;
          end
          if (state_d == S_IDLE) begin
            finish_d = 1'b1;
            valid_d  = is_read_q;
            error_d  = noack_q;
            rdata_d  = shreg_q;
          end else begin
            load = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    // Pad values for the bit that starts on this MDC falling edge
    if (load) begin
      oe_d  = (state_d inside {S_PRE, S_ST_OP, S_ADDR}) ||
              (!is_read_d && (state_d inside {S_TA, S_DATA}));
      out_d = (!oe_d || state_d == S_PRE) ? 1'b1 : tx_d[31];
    end
    if (state_d == S_IDLE) begin
      oe_d  = 1'b0;
      out_d = 1'b1;
    end
  end

  assign host.o_master_read_data       = rdata_q;
  assign host.o_master_read_data_valid = valid_q;
  assign host.o_operation_finish       = finish_q;
  assign host.o_mdio_master_busy       = (state_q != S_IDLE);
  assign host.o_error                  = error_q;
  assign o_mdc                         = mdc_q;
  assign o_mdio_out                    = out_q;
  assign o_mdio_oe                     = oe_q;

endmodule
